// File: rtl/uart_cmd_if.sv
// Command-result bundle produced by uart_cmd_rx: last good command, its strobe,
// the latched conversion step and the frame-drop strobe.
interface uart_cmd_if;
    logic [7:0]  m_cmd_code;
    logic [15:0] m_cmd_data;
    logic        m_cmd_valid;
    logic [6:0]  m_convert_config_step;
    logic        m_frame_err;

    modport master (
        output m_cmd_code, m_cmd_data, m_cmd_valid, m_convert_config_step, m_frame_err
    );
    modport slave (
        input  m_cmd_code, m_cmd_data, m_cmd_valid, m_convert_config_step, m_frame_err
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver plus 5-byte command frame parser (A5 cmd dhi dlo chk).
// Good frames update code/data and, for cmd 0x01, the conversion step register.
module uart_cmd_rx #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         BAUD_RATE    = 115200,
    parameter int         TIMEOUT_BITS = 20,
    parameter logic [6:0] STEP_RST     = 7'd0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    uart_cmd_if.master cmd
);
    localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam int TMO_CYC  = TIMEOUT_BITS * BIT_CYC;
    localparam int TMO_W    = $clog2(TMO_CYC + 1);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_t;
    typedef enum logic [2:0] {F_HDR, F_CMD, F_DHI, F_DLO, F_CHK} fr_st_t;

    // ---------------- synchroniser ----------------
    logic rx_m, rx_s, rx_d, rx_fall;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign rx_fall = rx_d & ~rx_s;

    // ---------------- bit FSM ----------------
    bit_st_t          bit_st, bit_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       sh;
    logic             half_hit, full_hit;
    logic             cnt_clr, shift_en, byte_ok_c, stop_err_c;
    logic             byte_ok, stop_err;

    assign half_hit = (cnt == HALF_LAST);
    assign full_hit = (cnt == FULL_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) bit_st <= B_IDLE;
        else         bit_st <= bit_nxt;
    end

    always_comb begin
        bit_nxt = bit_st;
        case (bit_st)
            B_IDLE:  if (rx_fall) bit_nxt = B_START;
            B_START: if (half_hit) bit_nxt = rx_s ? B_IDLE : B_DATA;
            B_DATA:  if (full_hit && bit_idx == 3'd7) bit_nxt = B_STOP;
            B_STOP:  if (full_hit) bit_nxt = B_IDLE;
            default: bit_nxt = B_IDLE;
        endcase
    end

    // Counter restarts on every state change, so DATA/STOP samples land mid-bit.
    always_comb begin
        shift_en   = (bit_st == B_DATA) && full_hit;
        byte_ok_c  = (bit_st == B_STOP) && full_hit && rx_s;
        stop_err_c = (bit_st == B_STOP) && full_hit && !rx_s;
        cnt_clr    = (bit_st == B_IDLE) || (bit_nxt != bit_st) || shift_en;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            byte_ok  <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (bit_st != B_DATA) bit_idx <= '0;
            else if (shift_en)    bit_idx <= bit_idx + 3'd1;
            if (shift_en) sh <= {rx_s, sh[7:1]};
            byte_ok  <= byte_ok_c;
            stop_err <= stop_err_c;
        end
    end

    // ---------------- frame FSM ----------------
    fr_st_t           fr_st, fr_nxt;
    logic [7:0]       cmd_r, dhi_r, dlo_r;
    logic [TMO_W-1:0] tcnt;
    logic             tmo_run, tmo_hit, chk_ok, frm_err_c;

    assign tmo_run = (fr_st != F_HDR) && (bit_st == B_IDLE);
    assign tmo_hit = tmo_run && (tcnt == TMO_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) fr_st <= F_HDR;
        else         fr_st <= fr_nxt;
    end

    // A byte that lands on the timeout cycle wins: the gap ended in time.
    always_comb begin
        fr_nxt = fr_st;
        if (fr_st != F_HDR && stop_err) begin
            fr_nxt = F_HDR;
        end else if (byte_ok) begin
            case (fr_st)
                F_HDR:   if (sh == 8'hA5) fr_nxt = F_CMD;
                F_CMD:   fr_nxt = F_DHI;
                F_DHI:   fr_nxt = F_DLO;
                F_DLO:   fr_nxt = F_CHK;
                default: fr_nxt = F_HDR;
            endcase
        end else if (tmo_hit) begin
            fr_nxt = F_HDR;
        end
    end

    always_comb begin
        chk_ok    = (fr_st == F_CHK) && byte_ok && (sh == (cmd_r ^ dhi_r ^ dlo_r));
        frm_err_c = ((fr_st == F_CHK) && byte_ok && !chk_ok)
                  || ((fr_st != F_HDR) && stop_err)
                  || (tmo_hit && !byte_ok);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cmd_r                     <= '0;
            dhi_r                     <= '0;
            dlo_r                     <= '0;
            tcnt                      <= '0;
            cmd.m_cmd_code            <= '0;
            cmd.m_cmd_data            <= '0;
            cmd.m_cmd_valid           <= 1'b0;
            cmd.m_convert_config_step <= STEP_RST;
            cmd.m_frame_err           <= 1'b0;
        end else begin
            if (byte_ok && fr_st == F_CMD) cmd_r <= sh;
            if (byte_ok && fr_st == F_DHI) dhi_r <= sh;
            if (byte_ok && fr_st == F_DLO) dlo_r <= sh;

            if (fr_st == F_HDR || byte_ok || tmo_hit) tcnt <= '0;
            else if (tmo_run)                        tcnt <= tcnt + TMO_W'(1);

            cmd.m_cmd_valid <= chk_ok;
            cmd.m_frame_err <= frm_err_c;
            if (chk_ok) begin
                cmd.m_cmd_code <= cmd_r;
                cmd.m_cmd_data <= {dhi_r, dlo_r};
                if (cmd_r == 8'h01) cmd.m_convert_config_step <= dlo_r[6:0];
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: table of whole frames plus hand-written
// glitch, timeout, stop-error, reset and garbage sequences.
module tb_uart_cmd_rx;
    localparam int BIT = 16;   // 1_843_200 / 115200

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic rx      = 1'b1;

    uart_cmd_if cmd();

    uart_cmd_rx #(
        .CLK_FREQ    (1_843_200),
        .BAUD_RATE   (115200),
        .TIMEOUT_BITS(20),
        .STEP_RST    (7'd3)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .rx     (rx),
        .cmd    (cmd)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0, n_fail = 0;
    int n_val = 0, n_err = 0, n_both = 0, cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (cmd.m_cmd_valid) n_val++;
        if (cmd.m_frame_err) n_err++;
        if (cmd.m_cmd_valid && cmd.m_frame_err) n_both++;
    end

    typedef struct {
        logic [4:0][7:0] b;       // b[4] sent first
        int              gap;     // idle bit-times between bytes
        int              val;
        int              err;
        logic [7:0]      code;
        logic [15:0]     data;
        logic [6:0]      step;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BIT);
        end
        rx = stop_bit;
        idle(BIT);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [4:0][7:0] f, input int gap);
        for (int i = 4; i >= 0; i--) begin
            send_byte(f[i], 1'b1);
            if (i != 0) idle(gap * BIT);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] code,
                              input logic [15:0] data, input logic [6:0] step);
        check({tag, "_code"}, int'(cmd.m_cmd_code), int'(code));
        check({tag, "_data"}, int'(cmd.m_cmd_data), int'(data));
        check({tag, "_step"}, int'(cmd.m_convert_config_step), int'(step));
    endtask

    initial begin
        int v0, e0, t0, el;
        logic seen;

        vt[0] = '{b:{8'hA5,8'h01,8'h00,8'h0C,8'h0D}, gap:0,  val:1, err:0, code:8'h01, data:16'h000C, step:7'd12};
        vt[1] = '{b:{8'hA5,8'h01,8'h00,8'h0C,8'h0E}, gap:0,  val:0, err:1, code:8'h01, data:16'h000C, step:7'd12};
        vt[2] = '{b:{8'hA5,8'h07,8'h12,8'h34,8'h21}, gap:0,  val:1, err:0, code:8'h07, data:16'h1234, step:7'd12};
        vt[3] = '{b:{8'hA5,8'h01,8'hA5,8'hA5,8'h01}, gap:0,  val:1, err:0, code:8'h01, data:16'hA5A5, step:7'h25};
        vt[4] = '{b:{8'hA5,8'h01,8'h00,8'h85,8'h84}, gap:15, val:1, err:0, code:8'h01, data:16'h0085, step:7'd5};
        vt[5] = '{b:{8'hA5,8'h02,8'hFF,8'h00,8'hFD}, gap:19, val:1, err:0, code:8'h02, data:16'hFF00, step:7'd5};

        idle(4);
        check_outs("reset", 8'h00, 16'h0000, 7'd3);
        check("reset_valid", int'(cmd.m_cmd_valid), 0);
        check("reset_err", int'(cmd.m_frame_err), 0);
        sys_rst = 1'b0;
        idle(2 * BIT);

        // table-driven frames
        for (int k = 0; k < 6; k++) begin
            v0 = n_val; e0 = n_err;
            send_frame(vt[k].b, vt[k].gap);
            idle(4 * BIT);
            check($sformatf("vec%0d_valid_cnt", k), n_val - v0, vt[k].val);
            check($sformatf("vec%0d_err_cnt", k), n_err - e0, vt[k].err);
            check_outs($sformatf("vec%0d", k), vt[k].code, vt[k].data, vt[k].step);
        end

        // short low glitches, idle and mid-frame: never become a byte
        v0 = n_val; e0 = n_err;
        rx = 1'b0; idle(6); rx = 1'b1; idle(3 * BIT);
        check("glitch_idle_pulses", (n_val - v0) + (n_err - e0), 0);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h0C, 1'b1);
        rx = 1'b0; idle(6); rx = 1'b1; idle(2 * BIT);
        send_byte(8'h0D, 1'b1);
        idle(4 * BIT);
        check("glitch_frame_valid", n_val - v0, 1);
        check("glitch_frame_err", n_err - e0, 0);
        check("glitch_frame_step", int'(cmd.m_convert_config_step), 12);

        // inter-byte timeout after A5 01
        v0 = n_val; e0 = n_err;
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        t0 = cyc; seen = 1'b0;
        for (int i = 0; i < 30 * BIT && !seen; i++) begin
            @(posedge sys_clk);
            if (n_err != e0) seen = 1'b1;
        end
        el = cyc - t0;
        check("tmo_seen", int'(seen), 1);
        check("tmo_time_window", int'(el >= 300 && el <= 330), 1);
        idle(12 * BIT);
        check("tmo_err_cnt", n_err - e0, 1);
        check("tmo_valid_cnt", n_val - v0, 0);
        send_frame({8'hA5, 8'h03, 8'h00, 8'h01, 8'h02}, 0);
        idle(4 * BIT);
        check("after_tmo_valid", n_val - v0, 1);
        check_outs("after_tmo", 8'h03, 16'h0001, 7'd12);

        // stop-bit error inside a frame
        v0 = n_val; e0 = n_err;
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b0);
        idle(4 * BIT);
        check("stoperr_err_cnt", n_err - e0, 1);
        check("stoperr_valid_cnt", n_val - v0, 0);

        // reset in the middle of a byte's data bits
        send_byte(8'hA5, 1'b1);
        rx = 1'b0; idle(3 * BIT);
        sys_rst = 1'b1; idle(3);
        rx = 1'b1;
        check_outs("midrst", 8'h00, 16'h0000, 7'd3);
        idle(2);
        sys_rst = 1'b0;
        v0 = n_val; e0 = n_err;
        idle(25 * BIT);
        check("midrst_no_pulse", (n_val - v0) + (n_err - e0), 0);
        send_frame({8'hA5, 8'h01, 8'h00, 8'h0C, 8'h0D}, 0);
        idle(4 * BIT);
        check("midrst_valid", n_val - v0, 1);
        check("midrst_step", int'(cmd.m_convert_config_step), 12);

        // garbage in HDR is silently dropped
        v0 = n_val; e0 = n_err;
        send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h5A, 1'b1);
        idle(25 * BIT);
        check("garbage_pulses", (n_val - v0) + (n_err - e0), 0);
        send_frame({8'hA5, 8'h07, 8'h12, 8'h34, 8'h21}, 0);
        idle(4 * BIT);
        check("garbage_then_valid", n_val - v0, 1);
        check_outs("garbage_then", 8'h07, 16'h1234, 7'd12);

        check("valid_err_overlap", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
